// File: rtl/parking_gate_controller.sv
// Parking entry gate FSM plus a 15-slot occupancy map with an independent exit path.
// Optional macro PARKING_STATS_EN adds a saturating entry_total counter output.
module parking_gate_controller #(
  parameter int unsigned GATE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        entry_req,
  input  logic        exit_req,
  input  logic [3:0]  exit_slot,
  output logic        entry_ack,
  output logic [3:0]  entry_slot,
  output logic        entry_full,
  output logic        exit_ack,
  output logic        exit_err,
  output logic        gate_open,
  output logic [14:0] occupancy,
  output logic [3:0]  free_count
`ifdef PARKING_STATS_EN
  ,
  output logic [15:0] entry_total
`endif
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] OPEN       = 2'd1;
  localparam logic [1:0] WAIT_CLEAR = 2'd2;

  localparam logic [7:0] GATE_LOAD = 8'(GATE_CYCLES);

  logic [1:0]  state, state_next;
  logic [7:0]  gate_cnt, gate_cnt_next;
  logic        gate_open_next;
  logic [3:0]  free_idx;
  logic        has_free;
  logic        grant, reject;
  logic        rel_ok, rel_err;
  logic [14:0] sel_mask, set_mask, clr_mask;

  // Lowest-index free slot; the descending loop lets the smallest index win.
  always_comb begin
    free_idx = '0;
    has_free = 1'b0;
    for (int i = 14; i >= 0; i--) begin
      if (!occupancy[i]) begin
        free_idx = 4'(i);
        has_free = 1'b1;
      end
    end
  end

  // Index 15 shifts out of the 15-bit mask, so it can never match an occupied bit.
  always_comb begin
    sel_mask = 15'd1 << exit_slot;
    rel_ok   = exit_req && |(occupancy & sel_mask);
    rel_err  = exit_req && !rel_ok;
    clr_mask = rel_ok ? sel_mask : '0;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_next     = state;
    gate_cnt_next  = gate_cnt;
    gate_open_next = gate_open;
    grant          = 1'b0;
    reject         = 1'b0;
    case (state)
      IDLE: begin
        if (entry_req) begin
          if (has_free) begin
            grant          = 1'b1;
            gate_cnt_next  = GATE_LOAD;
            gate_open_next = 1'b1;
            state_next     = OPEN;
          end else begin
            reject     = 1'b1;
            state_next = WAIT_CLEAR;
          end
        end
      end
      OPEN: begin
        if (gate_cnt <= 8'd1) begin
          gate_cnt_next  = '0;
          gate_open_next = 1'b0;
          state_next     = WAIT_CLEAR;
        end else begin
          gate_cnt_next = gate_cnt - 8'd1;
        end
      end
      WAIT_CLEAR: begin
        if (!entry_req) state_next = IDLE;
      end
      default: begin
        state_next     = IDLE;
        gate_cnt_next  = '0;
        gate_open_next = 1'b0;
      end
    endcase
    set_mask = grant ? (15'd1 << free_idx) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      gate_open  <= 1'b0;
      occupancy  <= '0;
      free_count <= 4'd15;
      entry_slot <= '0;
      entry_ack  <= 1'b0;
      entry_full <= 1'b0;
      exit_ack   <= 1'b0;
      exit_err   <= 1'b0;
    end else begin
      state      <= state_next;
      gate_cnt   <= gate_cnt_next;
      gate_open  <= gate_open_next;
      // Grant and release never target the same bit: a grant only picks a zero bit.
      occupancy  <= (occupancy | set_mask) & ~clr_mask;
      free_count <= free_count - {3'b000, grant} + {3'b000, rel_ok};
      if (grant) entry_slot <= free_idx;
      entry_ack  <= grant;
      entry_full <= reject;
      exit_ack   <= rel_ok;
      exit_err   <= rel_err;
    end
  end

`ifdef PARKING_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_total <= '0;
    end else if (grant && (entry_total != 16'hFFFF)) begin
      entry_total <= entry_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench for parking_gate_controller: a slot-array reference model queues
// expected pulses; a monitor process pops and compares them as the DUT produces them.
module tb_parking_gate_controller;
  localparam int G = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        entry_req = 1'b0;
  logic        exit_req = 1'b0;
  logic [3:0]  exit_slot = 4'd0;
  logic        entry_ack, entry_full, exit_ack, exit_err, gate_open;
  logic [3:0]  entry_slot, free_count;
  logic [14:0] occupancy;
`ifdef PARKING_STATS_EN
  logic [15:0] entry_total;
`endif

  parking_gate_controller #(.GATE_CYCLES(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .entry_req  (entry_req),
    .exit_req   (exit_req),
    .exit_slot  (exit_slot),
    .entry_ack  (entry_ack),
    .entry_slot (entry_slot),
    .entry_full (entry_full),
    .exit_ack   (exit_ack),
    .exit_err   (exit_err),
    .gate_open  (gate_open),
    .occupancy  (occupancy),
    .free_count (free_count)
`ifdef PARKING_STATS_EN
    ,
    .entry_total(entry_total)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int due; bit full; logic [3:0] slot; } ent_t;
  typedef struct { int due; bit err; } ext_t;
  ent_t entry_q[$];
  ext_t exit_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  bit chk_en = 1'b0;

  // Reference model: slot array, remaining open cycles, and "car already served" flag.
  bit         taken [15];
  int         gate_left;
  bit         served;
  logic [3:0] m_slot;
  int         m_total;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] m_occ();
    logic [14:0] o = '0;
    for (int k = 0; k < 15; k++) if (taken[k]) o[k] = 1'b1;
    return o;
  endfunction

  function automatic int m_free();
    int n = 0;
    for (int k = 0; k < 15; k++) if (!taken[k]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 15; k++) taken[k] = 1'b0;
    gate_left = 0;
    served    = 1'b0;
    m_slot    = 4'd0;
    m_total   = 0;
    entry_q.delete();
    exit_q.delete();
  endtask

  // Advance the model across the coming rising edge, given the inputs it will sample.
  task automatic model_edge(input bit req, input bit xr, input logic [3:0] xs);
    bit pre [15];
    int lowest;
    bit ok;
    pre    = taken;
    lowest = -1;
    for (int k = 0; k < 15; k++) if (!pre[k] && lowest < 0) lowest = k;
    if (xr) begin
      ok = 1'b0;
      if (int'(xs) < 15) ok = pre[int'(xs)];
      if (ok) taken[int'(xs)] = 1'b0;
      exit_q.push_back('{due: edge_cnt + 1, err: !ok});
    end
    if (gate_left > 0) begin
      gate_left--;
    end else if (served) begin
      if (!req) served = 1'b0;
    end else if (req) begin
      served = 1'b1;
      if (lowest >= 0) begin
        taken[lowest] = 1'b1;
        m_slot    = 4'(lowest);
        gate_left = G;
        if (m_total < 65535) m_total++;
        entry_q.push_back('{due: edge_cnt + 1, full: 1'b0, slot: 4'(lowest)});
      end else begin
        entry_q.push_back('{due: edge_cnt + 1, full: 1'b1, slot: m_slot});
      end
    end
  endtask

  task automatic step(input bit req, input bit xr, input logic [3:0] xs);
    @(negedge clk);
    entry_req = req;
    exit_req  = xr;
    exit_slot = xs;
    model_edge(req, xr, xs);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic enter();
    step(1'b1, 1'b0, 4'd0);
    repeat (G + 2) step(1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_reset();
    chk_en    = 1'b0;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    #1;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_occupancy", occupancy, 15'h0000);
    check("rst_free_count", free_count, 4'd15);
    check("rst_entry_slot", entry_slot, 4'd0);
    check("rst_gate_open", gate_open, 1'b0);
    check("rst_pulses", {entry_ack, entry_full, exit_ack, exit_err}, 4'b0000);
    rst_n = 1'b1;
    model_edge(1'b0, 1'b0, 4'd0);
    chk_en = 1'b1;
  endtask

  // Monitor: pops expected pulses when due and compares registered state every cycle.
  initial begin
    forever begin
      ent_t e;
      ext_t x;
      @(posedge clk);
      #1;
      if (chk_en) begin
        if (entry_q.size() > 0 && entry_q[0].due == edge_cnt) begin
          e = entry_q.pop_front();
          check("sb_entry_ack", entry_ack, !e.full);
          check("sb_entry_full", entry_full, e.full);
        end else begin
          check("sb_no_entry_pulse", {entry_ack, entry_full}, 2'b00);
        end
        if (exit_q.size() > 0 && exit_q[0].due == edge_cnt) begin
          x = exit_q.pop_front();
          check("sb_exit_ack", exit_ack, !x.err);
          check("sb_exit_err", exit_err, x.err);
        end else begin
          check("sb_no_exit_pulse", {exit_ack, exit_err}, 2'b00);
        end
        check("sb_occupancy", occupancy, m_occ());
        check("sb_free_count", free_count, m_free());
        check("sb_gate_open", gate_open, gate_left > 0);
        check("sb_entry_slot", entry_slot, m_slot);
        check("sb_invariant", 32'(free_count) + 32'($countones(occupancy)), 32'd15);
`ifdef PARKING_STATS_EN
        check("sb_entry_total", entry_total, m_total);
`endif
      end
    end
  end

  initial begin
    int acks, opens;
    bit req;
    logic [3:0] xs;
    int base;

    do_reset();

    // Held request: a single grant and exactly G open cycles.
    acks = 0;
    opens = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 4'd0);
      settle();
      if (i == 0) begin
        check("hold_ack", entry_ack, 1'b1);
        check("hold_slot", entry_slot, 4'd0);
        check("hold_occ", occupancy, 15'h0001);
        check("hold_free", free_count, 4'd14);
      end
      acks  += int'(entry_ack);
      opens += int'(gate_open);
    end
    check("hold_ack_count", acks, 1);
    check("hold_open_cycles", opens, G);
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);

    // Fill the lot, then one more request is rejected.
    repeat (14) enter();
    step(1'b1, 1'b0, 4'd0);
    settle();
    check("full_pulse", entry_full, 1'b1);
    check("full_occ", occupancy, 15'h7FFF);
    check("full_free", free_count, 4'd0);
    check("full_gate", gate_open, 1'b0);
    step(1'b1, 1'b0, 4'd0);
    settle();
    check("full_no_repeat", entry_full, 1'b0);
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);

    // Release down to 0x0007, free slot 1, and reuse it.
    for (int s = 3; s < 15; s++) step(1'b0, 1'b1, 4'(s));
    step(1'b0, 1'b1, 4'd1);
    settle();
    check("rel1_ack", exit_ack, 1'b1);
    check("rel1_occ", occupancy, 15'h0005);
    step(1'b1, 1'b0, 4'd0);
    settle();
    check("reuse_slot", entry_slot, 4'd1);
    check("reuse_occ", occupancy, 15'h0007);
    repeat (G + 2) step(1'b0, 1'b0, 4'd0);

    // Illegal releases.
    step(1'b0, 1'b1, 4'd15);
    settle();
    check("err15_pulse", exit_err, 1'b1);
    check("err15_occ", occupancy, 15'h0007);
    step(1'b0, 1'b1, 4'd9);
    settle();
    check("err9_pulse", exit_err, 1'b1);
    check("err9_occ", occupancy, 15'h0007);

    // Same-edge grant and release.
    step(1'b0, 1'b1, 4'd2);
    step(1'b1, 1'b1, 4'd0);
    settle();
    check("same_ack", entry_ack, 1'b1);
    check("same_slot", entry_slot, 4'd2);
    check("same_exit_ack", exit_ack, 1'b1);
    check("same_occ", occupancy, 15'h0006);
    check("same_free", free_count, 4'd13);
    repeat (G + 2) step(1'b0, 1'b0, 4'd0);

    // Releasing the slot granted on the same edge is illegal; the grant stands.
    step(1'b1, 1'b1, 4'd0);
    settle();
    check("clash_ack", entry_ack, 1'b1);
    check("clash_slot", entry_slot, 4'd0);
    check("clash_err", exit_err, 1'b1);
    check("clash_occ", occupancy, 15'h0007);
    repeat (G + 2) step(1'b0, 1'b0, 4'd0);

    // Randomized traffic, checked only by the scoreboard.
    req = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!req) req = ($urandom_range(0, 3) == 0);
      else      req = ($urandom_range(0, 6) != 0);
      xs = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 6) begin
        base = $urandom_range(0, 14);
        for (int k = 14; k >= 0; k--) if (taken[(base + k) % 15]) xs = 4'((base + k) % 15);
      end
      step(req, $urandom_range(0, 9) < 3, xs);
    end
    repeat (G + 3) step(1'b0, 1'b0, 4'd0);

    // Asynchronous reset in the third open cycle.
    do_reset();
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    @(posedge clk);
    #3;
    check("pre_rst_gate", gate_open, 1'b1);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_gate", gate_open, 1'b0);
    check("async_occ", occupancy, 15'h0000);
    check("async_free", free_count, 4'd15);
`ifdef PARKING_STATS_EN
    check("async_total", entry_total, 16'd0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_edge(1'b1, 1'b0, 4'd0);
    chk_en = 1'b1;
    settle();
    check("post_rst_ack", entry_ack, 1'b1);
    check("post_rst_slot", entry_slot, 4'd0);
    check("post_rst_occ", occupancy, 15'h0001);
    repeat (G + 3) step(1'b0, 1'b0, 4'd0);
    settle();

    check("entry_q_drained", entry_q.size(), 0);
    check("exit_q_drained", exit_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_gate_controller.md
PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

Interface
REQ-001 Parameter GATE_CYCLES, default 8, meaning number of cycles gate_open is held high after a grant (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 entry_req  input  1  car present at entry gate, level; held until the car passes.
REQ-005 exit_req  input  1  exit event strobe; sampled every cycle.
REQ-006 exit_slot  input  4  slot index being vacated, valid with exit_req.
REQ-007 entry_ack  output  1  one-cycle pulse: slot granted.
REQ-008 entry_slot  output  4  granted slot index (0..14); holds its value until the next grant.
REQ-009 entry_full  output  1  one-cycle pulse: request rejected, no free slot.
REQ-010 exit_ack  output  1  one-cycle pulse: slot released.
REQ-011 exit_err  output  1  one-cycle pulse: illegal release (index 15, or slot not occupied).
REQ-012 gate_open  output  1  entry barrier open, registered.
REQ-013 occupancy  output  15  registered occupancy map; bit k=1 means slot k taken.
REQ-014 free_count  output  4  registered count of zero bits in occupancy (0..15).

Function
REQ-015 Entry FSM states: IDLE, OPEN, WAIT_CLEAR.
REQ-016 IDLE with entry_req=1 and a free slot: at that edge, set occupancy bit k and load entry_slot=k, where k is the lowest index with a zero bit; pulse entry_ack; load gate counter; go to OPEN. Latency is one cycle from entry_req sample to entry_ack.
REQ-017 IDLE with entry_req=1 and occupancy all ones: pulse entry_full; leave occupancy unchanged; go to WAIT_CLEAR.
REQ-018 OPEN: gate_open=1 for exactly GATE_CYCLES consecutive cycles, starting the cycle entry_ack is high; then go to WAIT_CLEAR with gate_open=0.
REQ-019 WAIT_CLEAR: go to IDLE on the first edge where entry_req=0; a held entry_req never causes a second grant or a repeated entry_full.
REQ-020 Exit path is independent of FSM state: on each edge with exit_req=1 and exit_slot<15 and occupancy[exit_slot]=1, clear that bit and pulse exit_ack next cycle; otherwise pulse exit_err and leave occupancy unchanged.
REQ-021 A held exit_req is processed every cycle, so a second cycle for the same slot yields exit_err.
REQ-022 Same-edge grant and release: the search uses pre-edge occupancy; both the set and the clear apply at that edge; free_count reflects the net change.
REQ-023 Release of the slot being granted on the same edge is illegal (bit still 0 pre-edge): exit_err pulses and the grant stands.
REQ-024 free_count updates at the same edge as occupancy; invariant: free_count + popcount(occupancy) = 15.
REQ-025 entry_ack, entry_full, exit_ack and exit_err are never high for two consecutive cycles from a single event.

Reset
REQ-026 rst_n low asynchronously forces: occupancy=0, free_count=15, entry_slot=0, all pulse outputs=0, gate_open=0, gate counter=0, FSM=IDLE.
REQ-027 Reset asserted mid-OPEN closes the gate immediately; after release, a still-high entry_req is treated as a new request in IDLE.

Configuration
REQ-028 Macro PARKING_STATS_EN: when defined, add output entry_total [15:0], reset 0, incremented on every entry_ack and saturating at 16'hFFFF.
REQ-029 When PARKING_STATS_EN is undefined, the entry_total port and its logic are absent, and all other behaviour is identical.

Verification
REQ-030 Reset, then entry_req high for 20 cycles -> one entry_ack with entry_slot=0, occupancy=15'h0001, free_count=14, gate_open high for 8 cycles, no second ack.
REQ-031 Fill slots 0..14 with 15 separate requests, then request again -> entry_full pulse, occupancy=15'h7FFF, free_count=0, gate_open stays 0.
REQ-032 occupancy=15'h0007; exit_slot=1 with exit_req, then a new entry -> exit_ack, occupancy=15'h0005, then entry_slot=1, occupancy=15'h0007.
REQ-033 exit_req with exit_slot=15, and separately with an empty slot 9 -> exit_err each time, occupancy unchanged.
REQ-034 occupancy=15'h0003; grant (slot 2) and exit_slot=0 on the same edge -> entry_slot=2, exit_ack, occupancy=15'h0006, free_count=13.
REQ-035 rst_n low during OPEN (cycle 3 of 8) -> gate_open=0 and occupancy=0 without waiting for a clock edge; with PARKING_STATS_EN, entry_total=0.
